// File: rtl/mac_host_pkg.sv
// Shared definitions for the MAC host-bus register front-end:
// register map, FSM states and the latched request record.
package mac_host_pkg;

    localparam logic [7:0] MAC_REG_MODE  = 8'h00;
    localparam logic [7:0] MAC_REG_TXRX  = 8'h02;
    // Station address bytes, ADDR0 is the least significant byte.
    localparam logic [7:0] MAC_REG_ADDR0 = 8'h0e;
    localparam logic [7:0] MAC_REG_ADDR1 = 8'h0f;
    localparam logic [7:0] MAC_REG_ADDR2 = 8'h0c;
    localparam logic [7:0] MAC_REG_ADDR3 = 8'h0d;
    localparam logic [7:0] MAC_REG_ADDR4 = 8'h0a;
    localparam logic [7:0] MAC_REG_ADDR5 = 8'h0b;

    typedef enum logic [1:0] {IDLE, WAIT, ACK, RELEASE} host_state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic       wr;
    } host_req_t;

    function automatic logic reg_defined(input logic [7:0] a);
        return a inside {MAC_REG_MODE, MAC_REG_TXRX, MAC_REG_ADDR0, MAC_REG_ADDR1,
                         MAC_REG_ADDR2, MAC_REG_ADDR3, MAC_REG_ADDR4, MAC_REG_ADDR5};
    endfunction

endpackage

// File: rtl/mac_host_if.sv
// MAC host bus: chip-select/strobe request side and ack/read-data response side.
interface mac_host_if;
    logic       hcs_n;
    logic [7:0] haddr;
    logic [7:0] hdatain;
    logic       hwrite_n;
    logic       hread_n;
    logic       hready_n;
    logic       hdataout_en_n;
    logic [7:0] hdataout;

    modport master (
        output hcs_n, haddr, hdatain, hwrite_n, hread_n,
        input  hready_n, hdataout_en_n, hdataout
    );

    modport slave (
        input  hcs_n, haddr, hdatain, hwrite_n, hread_n,
        output hready_n, hdataout_en_n, hdataout
    );
endinterface

// File: rtl/mac_host_regfile.sv
// MAC configuration storage: address decode, write commit, read mux, cfg_wr pulse.
module mac_host_regfile
    import mac_host_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR_RST = 48'h0,
    parameter logic [7:0]  MODE_RST     = 8'h00,
    parameter logic [7:0]  TXRX_RST     = 8'h00
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [7:0]  addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic [47:0] mac_addr,
    output logic [7:0]  mode_reg,
    output logic [7:0]  txrx_ctl,
    output logic        cfg_wr
);

    // wr_en arrives on the edge that enters ACK, so new data and cfg_wr
    // appear in the same cycle as the ack.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            mac_addr <= MAC_ADDR_RST;
            mode_reg <= MODE_RST;
            txrx_ctl <= TXRX_RST;
            cfg_wr   <= 1'b0;
        end else begin
            cfg_wr <= wr_en && reg_defined(addr);
            if (wr_en) begin
                case (addr)
                    MAC_REG_MODE:  mode_reg         <= wdata;
                    MAC_REG_TXRX:  txrx_ctl         <= wdata;
                    MAC_REG_ADDR5: mac_addr[47:40]  <= wdata;
                    MAC_REG_ADDR4: mac_addr[39:32]  <= wdata;
                    MAC_REG_ADDR3: mac_addr[31:24]  <= wdata;
                    MAC_REG_ADDR2: mac_addr[23:16]  <= wdata;
                    MAC_REG_ADDR1: mac_addr[15:8]   <= wdata;
                    MAC_REG_ADDR0: mac_addr[7:0]    <= wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (rd_en) begin
            case (addr)
                MAC_REG_MODE:  rdata = mode_reg;
                MAC_REG_TXRX:  rdata = txrx_ctl;
                MAC_REG_ADDR5: rdata = mac_addr[47:40];
                MAC_REG_ADDR4: rdata = mac_addr[39:32];
                MAC_REG_ADDR3: rdata = mac_addr[31:24];
                MAC_REG_ADDR2: rdata = mac_addr[23:16];
                MAC_REG_ADDR1: rdata = mac_addr[15:8];
                MAC_REG_ADDR0: rdata = mac_addr[7:0];
                default:       rdata = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/mac_host_regs.sv
// Host-bus responder for the MAC register interface: request FSM with a
// programmable ack latency in front of the configuration register file.
module mac_host_regs
    import mac_host_pkg::*;
#(
    parameter int unsigned ACK_LAT      = 2,
    parameter logic [47:0] MAC_ADDR_RST = 48'h0,
    parameter logic [7:0]  MODE_RST     = 8'h00,
    parameter logic [7:0]  TXRX_RST     = 8'h00
) (
    input  logic        clk,
    input  logic        srst,
    mac_host_if.slave   bus,
    output logic [47:0] mac_addr,
    output logic [7:0]  mode_reg,
    output logic [7:0]  txrx_ctl,
    output logic        cfg_wr,
    output logic        proto_err
);

    // WAIT lasts ACK_LAT cycles, so the counter starts one below the latency.
    localparam logic [3:0] CNT_LOAD = 4'(ACK_LAT - 1);

    host_state_t state, state_nxt;
    host_req_t   req_q;
    logic [3:0]  cnt;
    logic        req;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  rdata;

    assign req = !bus.hcs_n && (!bus.hwrite_n || !bus.hread_n);

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_q     <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) begin
                cnt        <= CNT_LOAD;
                req_q.addr <= bus.haddr;
                req_q.data <= bus.hdatain;
                // Both strobes low is handled as a write.
                req_q.wr   <= !bus.hwrite_n;
                if (!bus.hwrite_n && !bus.hread_n)
                    proto_err <= 1'b1;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req)       state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = ACK;
            ACK:                    state_nxt = RELEASE;
            RELEASE: if (bus.hcs_n) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    assign wr_en = (state == WAIT) && (cnt == '0) && req_q.wr;
    assign rd_en = (state == ACK) && !req_q.wr;

    assign bus.hready_n      = (state != ACK);
    assign bus.hdataout_en_n = !rd_en;
    assign bus.hdataout      = rdata;

    mac_host_regfile #(
        .MAC_ADDR_RST (MAC_ADDR_RST),
        .MODE_RST     (MODE_RST),
        .TXRX_RST     (TXRX_RST)
    ) u_regfile (
        .clk      (clk),
        .srst     (srst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr     (req_q.addr),
        .wdata    (req_q.data),
        .rdata    (rdata),
        .mac_addr (mac_addr),
        .mode_reg (mode_reg),
        .txrx_ctl (txrx_ctl),
        .cfg_wr   (cfg_wr)
    );

endmodule

// File: tb/tb_mac_host_regs.sv
// Bench for mac_host_regs: transaction-timed reference model with per-cycle
// compare on the ACK_LAT=2 instance, plus directed checks and latency instances.
module tb_mac_host_regs;

    localparam int          L      = 2;
    localparam logic [47:0] MRST   = 48'h02_00_00_00_00_01;
    localparam logic [7:0]  MODE_R = 8'h11;
    localparam logic [7:0]  TXRX_R = 8'h22;

    logic clk = 1'b0;
    logic srst = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 0;

    mac_host_if bus();
    mac_host_if bus1();
    mac_host_if bus4();

    logic [47:0] mac_addr, mac1, mac4;
    logic [7:0]  mode_reg, txrx_ctl, mode1, txrx1, mode4, txrx4;
    logic        cfg_wr, cfg1, cfg4, perr, perr1, perr4;

    mac_host_regs #(.ACK_LAT(L), .MAC_ADDR_RST(MRST), .MODE_RST(MODE_R), .TXRX_RST(TXRX_R)) dut (
        .clk(clk), .srst(srst), .bus(bus), .mac_addr(mac_addr), .mode_reg(mode_reg),
        .txrx_ctl(txrx_ctl), .cfg_wr(cfg_wr), .proto_err(perr));

    mac_host_regs #(.ACK_LAT(1)) dut1 (
        .clk(clk), .srst(srst), .bus(bus1), .mac_addr(mac1), .mode_reg(mode1),
        .txrx_ctl(txrx1), .cfg_wr(cfg1), .proto_err(perr1));

    mac_host_regs #(.ACK_LAT(4)) dut4 (
        .clk(clk), .srst(srst), .bus(bus4), .mac_addr(mac4), .mode_reg(mode4),
        .txrx_ctl(txrx4), .cfg_wr(cfg4), .proto_err(perr4));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mreg [256];
    logic       e_ack, e_cfg, e_rd, e_perr;
    logic [7:0] e_rdata;
    int         cyc = 0, t_samp = 0, t_ack = 0;
    bit         busy, rel;
    logic [7:0] a_addr, a_data;
    bit         a_wr;

    function automatic bit defined(input logic [7:0] a);
        return a inside {8'h00, 8'h02, [8'h0a:8'h0f]};
    endfunction

    function automatic logic [47:0] exp_mac();
        return {mreg[8'h0b], mreg[8'h0a], mreg[8'h0d], mreg[8'h0c], mreg[8'h0f], mreg[8'h0e]};
    endfunction

    task automatic m_reset();
        logic [47:0] r;
        r = MRST;
        foreach (mreg[i]) mreg[i] = 8'h00;
        mreg[8'h0b] = r[47:40]; mreg[8'h0a] = r[39:32]; mreg[8'h0d] = r[31:24];
        mreg[8'h0c] = r[23:16]; mreg[8'h0f] = r[15:8];  mreg[8'h0e] = r[7:0];
        mreg[8'h00] = MODE_R;   mreg[8'h02] = TXRX_R;
        e_ack = 0; e_cfg = 0; e_rd = 0; e_perr = 0; e_rdata = 8'h00;
        busy = 0; rel = 0;
    endtask

    // An access sampled at edge T acks in the cycle after edge T+L; the bus is
    // free again once hcs_n is seen high at an edge later than T+L+1.
    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge srst);
            if (srst) m_reset();
            else begin
                cyc++;
                e_ack = 0; e_cfg = 0; e_rd = 0; e_rdata = 8'h00;
                if (busy && cyc == t_samp + L) begin
                    e_ack = 1; busy = 0; rel = 1; t_ack = cyc;
                    if (a_wr) begin
                        if (defined(a_addr)) begin mreg[a_addr] = a_data; e_cfg = 1; end
                    end else begin
                        e_rd = 1;
                        e_rdata = defined(a_addr) ? mreg[a_addr] : 8'h00;
                    end
                end else if (rel) begin
                    if (cyc > t_ack + 1 && bus.hcs_n) rel = 0;
                end else if (!busy && !bus.hcs_n && (!bus.hwrite_n || !bus.hread_n)) begin
                    busy = 1; t_samp = cyc;
                    a_addr = bus.haddr; a_data = bus.hdatain; a_wr = !bus.hwrite_n;
                    if (!bus.hwrite_n && !bus.hread_n) e_perr = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("hready_n",      64'(bus.hready_n),      64'(!e_ack));
            chk("hdataout_en_n", 64'(bus.hdataout_en_n), 64'(!e_rd));
            chk("hdataout",      64'(bus.hdataout),      64'(e_rdata));
            chk("cfg_wr",        64'(cfg_wr),            64'(e_cfg));
            chk("proto_err",     64'(perr),              64'(e_perr));
            chk("mac_addr",      64'(mac_addr),          64'(exp_mac()));
            chk("mode_reg",      64'(mode_reg),          64'(mreg[8'h00]));
            chk("txrx_ctl",      64'(txrx_ctl),          64'(mreg[8'h02]));
        end
    end

    int ack_cnt = 0, cfg_cnt = 0;
    always @(negedge clk) begin
        if (!bus.hready_n) ack_cnt++;
        if (cfg_wr) cfg_cnt++;
    end

    // ---------------- driver ----------------
    logic [7:0] rdv;
    int         lat;

    task automatic access(input logic [7:0] a, input logic [7:0] d, input bit wr, input bit rd,
                          input int hold, input bit scramble);
        bit got;
        bus.hcs_n = 1'b0; bus.haddr = a; bus.hdatain = d;
        bus.hwrite_n = !wr; bus.hread_n = !rd;
        @(posedge clk);
        got = 0; lat = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (!bus.hready_n) begin got = 1; lat = t; rdv = bus.hdataout; break; end
            if (scramble) begin
                bus.haddr = 8'($urandom); bus.hdatain = 8'($urandom);
                bus.hwrite_n = 1'($urandom); bus.hread_n = 1'($urandom);
                bus.hcs_n = 1'($urandom);
            end
        end
        chk("ack_seen", 64'(got), 64'd1);
        repeat (hold) @(negedge clk);
        bus.hcs_n = 1'b1; bus.hwrite_n = 1'b1; bus.hread_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    logic [7:0] bu_a [8] = '{8'h0b, 8'h0a, 8'h0d, 8'h0c, 8'h0f, 8'h0e, 8'h02, 8'h00};
    logic [7:0] bu_d [8] = '{8'hAC, 8'hDE, 8'h48, 8'h00, 8'h00, 8'h80, 8'hC2, 8'h0E};

    initial begin
        int a0, c0, lat1, lat4, n1, n4;
        logic [7:0] tx1, tx4;
        logic [7:0] ra;
        int op;

        bus.hcs_n = 1; bus.haddr = 0; bus.hdatain = 0; bus.hwrite_n = 1; bus.hread_n = 1;
        bus1.hcs_n = 1; bus1.haddr = 0; bus1.hdatain = 0; bus1.hwrite_n = 1; bus1.hread_n = 1;
        bus4.hcs_n = 1; bus4.haddr = 0; bus4.hdatain = 0; bus4.hwrite_n = 1; bus4.hread_n = 1;
        #1 srst = 1'b1;
        #1 chk_on = 1;
        repeat (3) @(negedge clk);
        srst = 1'b0;

        // bring-up
        a0 = ack_cnt; c0 = cfg_cnt;
        for (int i = 0; i < 8; i++) begin
            access(bu_a[i], bu_d[i], 1, 0, 0, 0);
            chk("bringup_lat", 64'(lat), 64'd2);
        end
        chk("bringup_mac",  64'(mac_addr), 64'h0000_ACDE_4800_0080);
        chk("bringup_txrx", 64'(txrx_ctl), 64'hC2);
        chk("bringup_mode", 64'(mode_reg), 64'h0E);
        chk("bringup_acks", 64'(ack_cnt - a0), 64'd8);
        chk("bringup_cfg",  64'(cfg_cnt - c0), 64'd8);

        // readback
        access(8'h0e, 8'h80, 1, 0, 0, 0);
        c0 = cfg_cnt;
        access(8'h0e, 8'h00, 0, 1, 0, 0);
        chk("read_0e", 64'(rdv), 64'h80);
        access(8'h30, 8'h00, 0, 1, 0, 0);
        chk("read_30", 64'(rdv), 64'h00);
        chk("read_no_cfg", 64'(cfg_cnt - c0), 64'd0);

        // held chip select
        a0 = ack_cnt; c0 = cfg_cnt;
        access(8'h02, 8'h5A, 1, 0, 9, 0);
        chk("held_acks", 64'(ack_cnt - a0), 64'd1);
        chk("held_cfg",  64'(cfg_cnt - c0), 64'd1);
        chk("held_txrx", 64'(txrx_ctl), 64'h5A);

        // both strobes low
        access(8'h00, 8'h3C, 1, 1, 0, 0);
        chk("perr_mode", 64'(mode_reg), 64'h3C);
        chk("perr_set",  64'(perr), 64'd1);
        access(8'h00, 8'h00, 0, 1, 0, 0);
        chk("perr_read", 64'(rdv), 64'h3C);
        chk("perr_sticky", 64'(perr), 64'd1);

        // latency at ACK_LAT=1 and 4
        bus1.hcs_n = 0; bus1.haddr = 8'h02; bus1.hdatain = 8'h55; bus1.hwrite_n = 0;
        bus4.hcs_n = 0; bus4.haddr = 8'h02; bus4.hdatain = 8'h55; bus4.hwrite_n = 0;
        @(posedge clk);
        lat1 = -1; lat4 = -1; n1 = 0; n4 = 0; tx1 = 0; tx4 = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (!bus1.hready_n) begin n1++; if (lat1 < 0) begin lat1 = t; tx1 = txrx1; end end
            if (!bus4.hready_n) begin n4++; if (lat4 < 0) begin lat4 = t; tx4 = txrx4; end end
            if (t == 5) begin
                bus1.hcs_n = 1; bus1.hwrite_n = 1;
                bus4.hcs_n = 1; bus4.hwrite_n = 1;
            end
        end
        chk("lat1", 64'(lat1), 64'd1);
        chk("lat4", 64'(lat4), 64'd4);
        chk("lat1_acks", 64'(n1), 64'd1);
        chk("lat4_acks", 64'(n4), 64'd1);
        chk("lat1_txrx", 64'(tx1), 64'h55);
        chk("lat4_txrx", 64'(tx4), 64'h55);

        // reset during WAIT
        bus.hcs_n = 0; bus.haddr = 8'h0b; bus.hdatain = 8'hFF; bus.hwrite_n = 0;
        @(posedge clk);
        @(negedge clk);
        #2 srst = 1'b1;
        #1;
        chk("rst_hready", 64'(bus.hready_n), 64'd1);
        chk("rst_mac", 64'(mac_addr), 64'h0000_0200_0000_0001);
        chk("rst_perr", 64'(perr), 64'd0);
        bus.hcs_n = 1; bus.hwrite_n = 1;
        @(negedge clk);
        srst = 1'b0;
        access(8'h0b, 8'h00, 0, 1, 0, 0);
        chk("rst_idle_lat", 64'(lat), 64'd2);
        chk("rst_read_0b", 64'(rdv), 64'h02);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            op = $urandom_range(0, 19);
            access(ra, 8'($urandom), op < 10 || op == 19, op >= 10, $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
        end

        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule
